// File: rtl/answer_checker_if.sv
// Bus between the expression/keypad front end and answer_checker.
// Master drives the question and keypad strobes; slave returns status, values and score.
interface answer_checker_if #(
    parameter int unsigned SCORE_W = 8
);
    logic [11:0]        exp;
    logic [1:0]         line;
    logic               load;
    logic               digit_valid;
    logic [3:0]         digit;
    logic               enter;
    logic               busy;
    logic               ready;
    logic               correct;
    logic               wrong;
    logic [6:0]         result;
    logic [6:0]         entry;
    logic [1:0]         line_q;
    logic [SCORE_W-1:0] score;

    modport master (
        output exp, line, load, digit_valid, digit, enter,
        input  busy, ready, correct, wrong, result, entry, line_q, score
    );

    modport slave (
        input  exp, line, load, digit_valid, digit, enter,
        output busy, ready, correct, wrong, result, entry, line_q, score
    );
endinterface

// File: rtl/answer_checker.sv
// answer_checker: latches a {num1, op, num2} question, evaluates it with
// iterative arithmetic, collects a two-digit keypad answer, judges it and
// keeps a saturating score.
// Optional macro ANSWER_TIMEOUT_EN adds a per-question answer timer of
// TIMEOUT_CYCLES cycles; without it the answer entry waits indefinitely.
module answer_checker #(
    parameter int unsigned SCORE_W        = 8,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
    input  logic              clk,
    input  logic              rst,
    answer_checker_if.slave   bus
);

    localparam int unsigned NUM_W   = 4;
    localparam int unsigned VAL_W   = 7;
    localparam int unsigned TIMER_W = 24;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_INPUT = 2'd2;
    localparam logic [1:0] S_JUDGE = 2'd3;

    localparam logic [NUM_W-1:0] OP_ADD = 4'hA;
    localparam logic [NUM_W-1:0] OP_SUB = 4'hB;
    localparam logic [NUM_W-1:0] OP_MUL = 4'hC;
    localparam logic [NUM_W-1:0] OP_DIV = 4'hD;

    logic [1:0]         state,   state_n;
    logic [NUM_W-1:0]   num1,    num1_n;
    logic [NUM_W-1:0]   num2,    num2_n;
    logic [NUM_W-1:0]   op,      op_n;
    // Iteration scratch: remaining additions for multiply, remainder for divide.
    logic [NUM_W-1:0]   work,    work_n;
    logic [1:0]         ndig,    ndig_n;
    logic [VAL_W-1:0]   result,  result_n;
    logic [VAL_W-1:0]   entry,   entry_n;
    logic [1:0]         line_q,  line_q_n;
    logic [SCORE_W-1:0] score,   score_n;
    logic               busy,    busy_n;
    logic               ready,   ready_n;
    logic               correct, correct_n;
    logic               wrong,   wrong_n;
    logic               take_load_c;
    logic               digit_ok_c;

`ifdef ANSWER_TIMEOUT_EN
    logic [TIMER_W-1:0] timer,   timer_n;
    logic               expired_c;
`else
    // The timeout length has no effect when the timer is not built.
    logic               unused_timeout_c;
    assign unused_timeout_c = ^TIMEOUT_CYCLES;
`endif

    // A new question is accepted only while idle or while answer entry is open.
    assign take_load_c = bus.load && ((state == S_IDLE) || (state == S_INPUT));

    // A keypad digit is usable when it is BCD and the two-digit entry is not full.
    assign digit_ok_c = bus.digit_valid && (bus.digit <= 4'd9) && (ndig < 2'd2);

`ifdef ANSWER_TIMEOUT_EN
    // Last cycle of the answer window.
    assign expired_c = (timer == (TIMEOUT_CYCLES - TIMER_W'(1)));
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            num1    <= '0;
            num2    <= '0;
            op      <= '0;
            work    <= '0;
            ndig    <= '0;
            result  <= '0;
            entry   <= '0;
            line_q  <= '0;
            score   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            correct <= 1'b0;
            wrong   <= 1'b0;
`ifdef ANSWER_TIMEOUT_EN
            timer   <= '0;
`endif
        end else begin
            state   <= state_n;
            num1    <= num1_n;
            num2    <= num2_n;
            op      <= op_n;
            work    <= work_n;
            ndig    <= ndig_n;
            result  <= result_n;
            entry   <= entry_n;
            line_q  <= line_q_n;
            score   <= score_n;
            busy    <= busy_n;
            ready   <= ready_n;
            correct <= correct_n;
            wrong   <= wrong_n;
`ifdef ANSWER_TIMEOUT_EN
            timer   <= timer_n;
`endif
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n   = state;
        num1_n    = num1;
        num2_n    = num2;
        op_n      = op;
        work_n    = work;
        ndig_n    = ndig;
        result_n  = result;
        entry_n   = entry;
        line_q_n  = line_q;
        score_n   = score;
        correct_n = 1'b0;
        wrong_n   = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
        // Timer is zero on the first INPUT cycle and counts while entry stays open.
        timer_n   = (state == S_INPUT) ? (timer + TIMER_W'(1)) : '0;
`endif

        case (state)
            S_IDLE: begin
                // Only a load leaves IDLE; handled below.
            end

            S_EVAL: begin
                case (op)
                    OP_ADD: begin
                        result_n = VAL_W'(num1) + VAL_W'(num2);
                        state_n  = S_INPUT;
                    end
                    OP_SUB: begin
                        // Absolute difference so the unsigned result never wraps.
                        result_n = (num1 >= num2) ? VAL_W'(num1 - num2)
                                                  : VAL_W'(num2 - num1);
                        state_n  = S_INPUT;
                    end
                    OP_MUL: begin
                        if (work == '0) begin
                            state_n = S_INPUT;
                        end else begin
                            result_n = result + VAL_W'(num1);
                            work_n   = work - NUM_W'(1);
                            if (work == NUM_W'(1)) begin
                                state_n = S_INPUT;
                            end
                        end
                    end
                    OP_DIV: begin
                        if (num2 == '0) begin
                            result_n = '0;
                            state_n  = S_INPUT;
                        end else if (work >= num2) begin
                            work_n   = work - num2;
                            result_n = result + VAL_W'(1);
                        end else begin
                            state_n  = S_INPUT;
                        end
                    end
                    default: begin
                        wrong_n = 1'b1;
                        state_n = S_IDLE;
                    end
                endcase
            end

            S_INPUT: begin
                // A load in this state restarts the question below and overrides all else.
                if (!bus.load) begin
                    if (bus.enter && (ndig != 2'd0)) begin
                        state_n = S_JUDGE;
`ifdef ANSWER_TIMEOUT_EN
                    end else if (expired_c) begin
                        wrong_n = 1'b1;
                        state_n = S_IDLE;
`endif
                    end else if (digit_ok_c) begin
                        entry_n = (entry * VAL_W'(10)) + VAL_W'(bus.digit);
                        ndig_n  = ndig + 2'd1;
                    end
                end
            end

            S_JUDGE: begin
                if (entry == result) begin
                    correct_n = 1'b1;
                    if (score != {SCORE_W{1'b1}}) begin
                        score_n = score + SCORE_W'(1);
                    end
                end else begin
                    wrong_n = 1'b1;
                end
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (take_load_c) begin
            num1_n   = bus.exp[11:8];
            op_n     = bus.exp[7:4];
            num2_n   = bus.exp[3:0];
            work_n   = (bus.exp[7:4] == OP_MUL) ? bus.exp[3:0] : bus.exp[11:8];
            line_q_n = bus.line;
            result_n = '0;
            entry_n  = '0;
            ndig_n   = '0;
            state_n  = S_EVAL;
        end

        busy_n  = (state_n == S_EVAL) || (state_n == S_JUDGE);
        ready_n = (state_n == S_INPUT);
    end

    // Drive the bus from the registered outputs.
    assign bus.busy    = busy;
    assign bus.ready   = ready;
    assign bus.correct = correct;
    assign bus.wrong   = wrong;
    assign bus.result  = result;
    assign bus.entry   = entry;
    assign bus.line_q  = line_q;
    assign bus.score   = score;

endmodule
